// File: rtl/cam_masked_param.sv
// Parametrised ternary CAM: DEPTH entries of DATA_W bits, each with a valid bit.
// Masked search, invalidate, match count, occupancy tracking and free-slot finder; read/search results registered.
module cam_masked_param #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              read_enable_i,
    input  logic [IDX_W-1:0]  read_index_i,
    input  logic              write_enable_i,
    input  logic [IDX_W-1:0]  write_index_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              invalidate_enable_i,
    input  logic [IDX_W-1:0]  invalidate_index_i,
    input  logic              search_enable_i,
    input  logic [DATA_W-1:0] search_data_i,
    input  logic [DATA_W-1:0] search_mask_i,
    output logic              read_valid_o,
    output logic [DATA_W-1:0] read_value_o,
    output logic              search_valid_o,
    output logic [IDX_W-1:0]  search_index_o,
    output logic [CNT_W-1:0]  search_count_o,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              full_o,
    output logic              free_valid_o,
    output logic [IDX_W-1:0]  free_index_o
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [CNT_W-1:0]  occupancy_q;

    logic              wr_ok;
    logic              inv_ok;
    logic              rd_ok;
    logic              wr_new;
    logic              inv_drop;
    logic [DEPTH-1:0]  match;
    logic [IDX_W-1:0]  match_idx;
    logic [CNT_W-1:0]  match_cnt;
    logic [IDX_W-1:0]  free_idx;

    // Indices beyond DEPTH can only appear when DEPTH is not a power of two; such requests are dropped.
    assign wr_ok  = write_enable_i      && (32'(write_index_i)      < DEPTH);
    assign inv_ok = invalidate_enable_i && (32'(invalidate_index_i) < DEPTH);
    assign rd_ok  = read_enable_i       && (32'(read_index_i)       < DEPTH);

    // A write to the invalidated index wins, so that invalidate must not count as a removal.
    always_comb begin
        wr_new   = 1'b0;
        inv_drop = 1'b0;
        if (wr_ok)
            wr_new = !valid_q[write_index_i];
        if (inv_ok)
            inv_drop = valid_q[invalidate_index_i]
                       && !(wr_ok && (write_index_i == invalidate_index_i));
    end

    always_comb begin
        match     = '0;
        match_idx = '0;
        match_cnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            match[i] = valid_q[i] && (((data_q[i] ^ search_data_i) & search_mask_i) == '0);
            if (match[i])
                match_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++)
            match_cnt = match_cnt + CNT_W'(match[i]);
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i])
                free_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                data_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (write_index_i == IDX_W'(i))) begin
                    data_q[i]  <= write_data_i;
                    valid_q[i] <= 1'b1;
                end else if (inv_ok && (invalidate_index_i == IDX_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
            occupancy_q <= occupancy_q + CNT_W'(wr_new) - CNT_W'(inv_drop);
        end
    end

    // Read and search see the contents as they were before this edge's write/invalidate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_valid_o   <= 1'b0;
            read_value_o   <= '0;
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_count_o <= '0;
        end else begin
            read_valid_o   <= 1'b0;
            read_value_o   <= '0;
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_count_o <= '0;
            if (rd_ok && valid_q[read_index_i]) begin
                read_valid_o <= 1'b1;
                read_value_o <= data_q[read_index_i];
            end
            if (search_enable_i && (match != '0)) begin
                search_valid_o <= 1'b1;
                search_index_o <= match_idx;
                search_count_o <= match_cnt;
            end
        end
    end

    assign occupancy_o  = occupancy_q;
    assign full_o       = (occupancy_q == CNT_W'(DEPTH));
    assign free_valid_o = ~&valid_q;
    assign free_index_o = free_idx;

endmodule

// File: tb/tb_cam_masked_param.sv
// Directed self-checking bench for cam_masked_param (DEPTH=32, DATA_W=32).
// Each stimulus occupies one clock; registered outputs are sampled 1 time unit after the edge.
module tb_cam_masked_param;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int IW = 5;
    localparam int CW = 6;
    localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_enable;
    logic [IW-1:0] read_index;
    logic          write_enable;
    logic [IW-1:0] write_index;
    logic [DW-1:0] write_data;
    logic          invalidate_enable;
    logic [IW-1:0] invalidate_index;
    logic          search_enable;
    logic [DW-1:0] search_data;
    logic [DW-1:0] search_mask;
    logic          read_valid;
    logic [DW-1:0] read_value;
    logic          search_valid;
    logic [IW-1:0] search_index;
    logic [CW-1:0] search_count;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          free_valid;
    logic [IW-1:0] free_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_masked_param #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .read_enable_i       (read_enable),
        .read_index_i        (read_index),
        .write_enable_i      (write_enable),
        .write_index_i       (write_index),
        .write_data_i        (write_data),
        .invalidate_enable_i (invalidate_enable),
        .invalidate_index_i  (invalidate_index),
        .search_enable_i     (search_enable),
        .search_data_i       (search_data),
        .search_mask_i       (search_mask),
        .read_valid_o        (read_valid),
        .read_value_o        (read_value),
        .search_valid_o      (search_valid),
        .search_index_o      (search_index),
        .search_count_o      (search_count),
        .occupancy_o         (occupancy),
        .full_o              (full),
        .free_valid_o        (free_valid),
        .free_index_o        (free_index)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests, step past the edge, then return all inputs to idle.
    task automatic applyStimulus(
        input logic          r,
        input logic          re, input logic [IW-1:0] ri,
        input logic          we, input logic [IW-1:0] wi, input logic [DW-1:0] wd,
        input logic          ie, input logic [IW-1:0] ii,
        input logic          se, input logic [DW-1:0] sd, input logic [DW-1:0] sm);
        rst = r;
        read_enable = re;        read_index = ri;
        write_enable = we;       write_index = wi;  write_data = wd;
        invalidate_enable = ie;  invalidate_index = ii;
        search_enable = se;      search_data = sd;  search_mask = sm;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_enable = 1'b0;
        write_enable = 1'b0;
        invalidate_enable = 1'b0;
        search_enable = 1'b0;
    endtask

    task automatic writeEntry(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, idx, data, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic invalidateEntry(input logic [IW-1:0] idx);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, idx, 1'b0, '0, '0);
    endtask

    task automatic readEntry(input logic [IW-1:0] idx);
        applyStimulus(1'b0, 1'b1, idx, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic searchKey(input logic [DW-1:0] key, input logic [DW-1:0] mask);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, key, mask);
    endtask

    task automatic checkSearch(input string tag, input logic v, input logic [IW-1:0] idx, input logic [CW-1:0] cnt);
        checkOutput({tag, ".valid"}, 64'(search_valid), 64'(v));
        checkOutput({tag, ".index"}, 64'(search_index), 64'(idx));
        checkOutput({tag, ".count"}, 64'(search_count), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        read_enable = 1'b0;        read_index = '0;
        write_enable = 1'b0;       write_index = '0;  write_data = '0;
        invalidate_enable = 1'b0;  invalidate_index = '0;
        search_enable = 1'b0;      search_data = '0;  search_mask = '0;

        // Reset state and an empty-table read/search.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
        checkOutput("rst.occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst.full", 64'(full), 64'd0);
        checkOutput("rst.free_valid", 64'(free_valid), 64'd1);
        checkOutput("rst.free_index", 64'(free_index), 64'd0);
        applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h0, ONES);
        checkOutput("empty.read_valid", 64'(read_valid), 64'd0);
        checkOutput("empty.read_value", 64'(read_value), 64'd0);
        checkSearch("empty.search", 1'b0, '0, '0);

        // Two identical entries: lowest index reported, both counted.
        writeEntry(5'd3, 32'hDEAD_BEEF);
        writeEntry(5'd7, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF, ONES);
        checkSearch("dup.search", 1'b1, 5'd3, 6'd2);
        checkOutput("dup.read_valid", 64'(read_valid), 64'd1);
        checkOutput("dup.read_value", 64'(read_value), 64'hDEAD_BEEF);
        checkOutput("dup.occupancy", 64'(occupancy), 64'd2);
        checkOutput("dup.free_index", 64'(free_index), 64'd0);

        // Masked search.
        writeEntry(5'd4, 32'h1234_5678);
        searchKey(32'h1234_0000, 32'hFFFF_0000);
        checkSearch("mask.hi", 1'b1, 5'd4, 6'd1);
        searchKey(32'h1234_0000, ONES);
        checkSearch("mask.full", 1'b0, '0, '0);
        searchKey(32'h0, 32'h0);
        checkSearch("mask.zero", 1'b1, 5'd3, 6'd3);

        // Same-cycle write and search/read return the old contents.
        writeEntry(5'd2, 32'h0);
        applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 5'd2, 32'hA5, 1'b0, '0, 1'b1, 32'hA5, ONES);
        checkSearch("hazard.same", 1'b0, '0, '0);
        checkOutput("hazard.read_valid", 64'(read_valid), 64'd1);
        checkOutput("hazard.read_value", 64'(read_value), 64'd0);
        searchKey(32'hA5, ONES);
        checkSearch("hazard.next", 1'b1, 5'd2, 6'd1);
        checkOutput("hazard.occupancy", 64'(occupancy), 64'd4);

        // Invalidate, repeated invalidate, and write+invalidate on different indices.
        invalidateEntry(5'd3);
        checkOutput("inv.occupancy", 64'(occupancy), 64'd3);
        invalidateEntry(5'd3);
        checkOutput("inv.again.occupancy", 64'(occupancy), 64'd3);
        readEntry(5'd3);
        checkOutput("inv.read_valid", 64'(read_valid), 64'd0);
        checkOutput("inv.read_value", 64'(read_value), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd0, 32'h77, 1'b1, 5'd4, 1'b0, '0, '0);
        checkOutput("net.occupancy", 64'(occupancy), 64'd3);
        checkOutput("net.free_index", 64'(free_index), 64'd1);
        searchKey(32'h1234_5678, ONES);
        checkSearch("net.search", 1'b0, '0, '0);

        // Fill the table, then exercise the full boundary.
        for (int i = 0; i < D; i++)
            writeEntry(IW'(i), 32'h100 + 32'(i));
        checkOutput("fill.occupancy", 64'(occupancy), 64'(D));
        checkOutput("fill.full", 64'(full), 64'd1);
        checkOutput("fill.free_valid", 64'(free_valid), 64'd0);
        checkOutput("fill.free_index", 64'(free_index), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd9, 1'b0, '0, '0);
        checkOutput("wrinv.full", 64'(full), 64'd1);
        checkOutput("wrinv.occupancy", 64'(occupancy), 64'(D));
        readEntry(5'd9);
        checkOutput("wrinv.read_value", 64'(read_value), 64'h999);
        invalidateEntry(5'd9);
        checkOutput("free.occupancy", 64'(occupancy), 64'(D - 1));
        checkOutput("free.full", 64'(full), 64'd0);
        checkOutput("free.free_valid", 64'(free_valid), 64'd1);
        checkOutput("free.free_index", 64'(free_index), 64'd9);
        searchKey(32'h0, 32'h0);
        checkSearch("free.all", 1'b1, 5'd0, 6'(D - 1));
        searchKey(32'h999, ONES);
        checkSearch("free.gone", 1'b0, '0, '0);

        // Reset beats a same-cycle write and search.
        applyStimulus(1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 32'h55, 1'b0, '0, 1'b1, 32'h0, 32'h0);
        checkOutput("rst2.read_valid", 64'(read_valid), 64'd0);
        checkSearch("rst2.search", 1'b0, '0, '0);
        checkOutput("rst2.occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst2.free_valid", 64'(free_valid), 64'd1);
        checkOutput("rst2.free_index", 64'(free_index), 64'd0);
        searchKey(32'h0, 32'h0);
        checkSearch("rst2.after", 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
